// File: rtl/decode_scoreboard.sv
// decode_scoreboard: RAW/WAW hazard scoreboard for scalar+vector files, stall/flush/drain control.
// Optional stall-cycle statistics counter enabled by defining SCOREBOARD_STATS_EN.
module decode_scoreboard #(
  parameter int NREG = 32,
  parameter logic [6:0] VEC_OPCODE = 7'b1010111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic        BranchTakenE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic        VecW,
  input  logic        DrainReq,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        RegFileSelect,
  output logic        DrainAck,
  output logic [31:0] StallCycles
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;
  state_t state;
  logic [NREG-1:0] pend_s, pend_v, clr_s, clr_v, set_s, set_v, eff;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic vec_d, use1, use2, hazard, drain_block, issue, unused;
  assign op = InstrD[6:0];
  assign rd = InstrD[11:7];
  assign rs1 = InstrD[19:15];
  assign rs2 = InstrD[24:20];
  assign unused = ^{InstrD[31:25], InstrD[14:12]};
  assign vec_d = op == VEC_OPCODE;
  assign RegFileSelect = vec_d;
  assign use1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign use2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011 || vec_d;
  // Writeback in the same cycle bypasses: its bit is treated as already clear
  assign clr_s = (RegWriteW & ~VecW) ? NREG'(1) << RDW : '0;
  assign clr_v = (RegWriteW & VecW) ? NREG'(1) << RDW : '0;
  assign eff = vec_d ? pend_v & ~clr_v : pend_s & ~clr_s;
  assign hazard = ValidD & ((use1 & eff[rs1]) | (use2 & eff[rs2]) | (RegWriteD & eff[rd]));
  assign drain_block = state == DRAIN;
  assign issue = ValidD & ~hazard & ~BranchTakenE & ~drain_block;
  assign set_s = (issue & RegWriteD & ~vec_d & rd != 5'd0) ? NREG'(1) << rd : '0;
  assign set_v = (issue & RegWriteD & vec_d) ? NREG'(1) << rd : '0;
  assign StallD = rst & ~BranchTakenE & (hazard | drain_block);
  assign StallF = StallD;
  assign FlushE = rst & (BranchTakenE | hazard | drain_block);
  assign DrainAck = rst & DrainReq & drain_block & ~|pend_s & ~|pend_v;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pend_s <= '0;
      pend_v <= '0;
    end else begin
      pend_s <= (pend_s & ~clr_s) | set_s;
      pend_v <= (pend_v & ~clr_v) | set_v;
      state <= DrainReq ? DRAIN : drain_block ? RUN : (hazard & ~BranchTakenE) ? STALL : RUN;
    end
  end
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (StallD & hazard & ~drain_block & ~&count) count <= count + 32'd1;
  end
  assign StallCycles = count;
`else
  assign StallCycles = '0;
`endif
endmodule
